// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// whole-pipeline hold, branch flush and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] rs1_data_id,
    input  logic [XLEN-1:0] rs2_data_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic [4:0]      rd_id,
    input  logic [2:0]      funct3_id,
    input  logic [6:0]      funct7_id,
    input  logic            alusrc_id,
    input  logic            memtoreg_id,
    input  logic            regwrite_id,
    input  logic            memread_id,
    input  logic            memwrite_id,
    input  logic            branch_id,
    input  logic [1:0]      alu_op_id,
    input  logic            hold,
    input  logic            flush_ex,
    output logic            valid_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [2:0]      funct3_ex,
    output logic [6:0]      funct7_ex,
    output logic            alusrc_ex,
    output logic            memtoreg_ex,
    output logic            regwrite_ex,
    output logic            memread_ex,
    output logic            memwrite_ex,
    output logic            branch_ex,
    output logic [1:0]      alu_op_ex,
    output logic            stall_id,
    output logic [15:0]     hazard_count
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            alusrc;
        logic            memtoreg;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic [1:0]      alu_op;
    } ex_t;

    ex_t         ex_d, ex_q, ld;
    logic [15:0] cnt_d, cnt_q;
    logic        use_rs2, ctrl_on;

    always_comb begin
        use_rs2  = ~alusrc_id | memwrite_id | branch_id;
        stall_id = ~rst & ~flush_ex & valid_id & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0)
                 & ((ex_q.rd == rs1_id) | (use_rs2 & (ex_q.rd == rs2_id)));
        // Bubbles and invalid slots carry data through but never any control.
        ctrl_on  = valid_id & ~flush_ex & ~stall_id;
        ld = '{valid: ctrl_on, pc: pc_id, rs1_data: rs1_data_id, rs2_data: rs2_data_id,
               imm: imm_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id, funct3: funct3_id,
               funct7: funct7_id, alusrc: alusrc_id & ctrl_on, memtoreg: memtoreg_id & ctrl_on,
               regwrite: regwrite_id & ctrl_on, memread: memread_id & ctrl_on,
               memwrite: memwrite_id & ctrl_on, branch: branch_id & ctrl_on,
               alu_op: alu_op_id & {2{ctrl_on}}};
        ex_d  = hold ? ex_q : ld;
        cnt_d = (~hold & stall_id & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_ex     = ex_q.valid;
    assign pc_ex        = ex_q.pc;
    assign rs1_data_ex  = ex_q.rs1_data;
    assign rs2_data_ex  = ex_q.rs2_data;
    assign imm_ex       = ex_q.imm;
    assign rs1_ex       = ex_q.rs1;
    assign rs2_ex       = ex_q.rs2;
    assign rd_ex        = ex_q.rd;
    assign funct3_ex    = ex_q.funct3;
    assign funct7_ex    = ex_q.funct7;
    assign alusrc_ex    = ex_q.alusrc;
    assign memtoreg_ex  = ex_q.memtoreg;
    assign regwrite_ex  = ex_q.regwrite;
    assign memread_ex   = ex_q.memread;
    assign memwrite_ex  = ex_q.memwrite;
    assign branch_ex    = ex_q.branch;
    assign alu_op_ex    = ex_q.alu_op;
    assign hazard_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for the ID/EX stage, checked against a
// behavioural pipeline model every cycle plus literal spot checks.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst = 1'b1, preload = 1'b0;
    logic        valid_id = 0, hold = 0, flush_ex = 0;
    logic [31:0] pc_id = 0, rs1_data_id = 0, rs2_data_id = 0, imm_id = 0;
    logic [4:0]  rs1_id = 0, rs2_id = 0, rd_id = 0;
    logic [2:0]  funct3_id = 0;
    logic [6:0]  funct7_id = 0;
    logic        alusrc_id = 0, memtoreg_id = 0, regwrite_id = 0, memread_id = 0, memwrite_id = 0, branch_id = 0;
    logic [1:0]  alu_op_id = 0;
    logic        valid_ex, alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex, branch_ex, stall_id;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [2:0]  funct3_ex;
    logic [6:0]  funct7_ex;
    logic [1:0]  alu_op_ex;
    logic [15:0] hazard_count;
    int checks = 0, errors = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .funct3_id(funct3_id), .funct7_id(funct7_id), .alusrc_id(alusrc_id), .memtoreg_id(memtoreg_id),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
        .branch_id(branch_id), .alu_op_id(alu_op_id), .hold(hold), .flush_ex(flush_ex),
        .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
        .funct7_ex(funct7_ex), .alusrc_ex(alusrc_ex), .memtoreg_ex(memtoreg_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .branch_ex(branch_ex), .alu_op_ex(alu_op_ex), .stall_id(stall_id), .hazard_count(hazard_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of what EX must hold: control bits {alusrc,memtoreg,regwrite,memread,memwrite,branch,alu_op}.
    logic        m_valid, m_known;
    logic [7:0]  m_ctl;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [15:0] m_cnt;

    function automatic logic m_stall();
        logic reads_rs2;
        reads_rs2 = !alusrc_id || memwrite_id || branch_id;
        return !rst && !flush_ex && valid_id && m_valid && m_ctl[4] && m_rd != 0 &&
               (m_rd == rs1_id || (reads_rs2 && m_rd == rs2_id));
    endfunction

    always @(posedge clk or posedge rst or posedge preload) begin
        if (rst) begin
            m_valid = 0; m_known = 1; m_ctl = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_cnt = 0;
        end else if (preload) begin
            m_cnt = 16'hFFFE;
        end else if (!hold) begin
            if (flush_ex || m_stall()) begin
                if (m_stall() && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                m_valid = 0; m_ctl = 0; m_known = 0;
            end else begin
                m_valid = valid_id;
                m_ctl = valid_id ? {alusrc_id, memtoreg_id, regwrite_id, memread_id, memwrite_id, branch_id, alu_op_id} : 8'd0;
                m_pc = pc_id; m_d1 = rs1_data_id; m_d2 = rs2_data_id; m_imm = imm_id;
                m_rs1 = rs1_id; m_rs2 = rs2_id; m_rd = rd_id; m_f3 = funct3_id; m_f7 = funct7_id;
                m_known = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_ex", {31'd0, valid_ex}, {31'd0, m_valid});
        chk("ctl_ex", {24'd0, alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex, branch_ex, alu_op_ex}, {24'd0, m_ctl});
        chk("hazard_count", {16'd0, hazard_count}, {16'd0, m_cnt});
        chk("stall_id", {31'd0, stall_id}, {31'd0, m_stall()});
        if (m_known) begin
            chk("pc_ex", pc_ex, m_pc);
            chk("rs1_data_ex", rs1_data_ex, m_d1);
            chk("rs2_data_ex", rs2_data_ex, m_d2);
            chk("imm_ex", imm_ex, m_imm);
            chk("fields_ex", {12'd0, rs1_ex, rs2_ex, rd_ex, funct3_ex, funct7_ex}, {12'd0, m_rs1, m_rs2, m_rd, m_f3, m_f7});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic as, input logic rw, input logic mr,
                          input logic mw, input logic br, input logic [1:0] op);
        valid_id = v; rd_id = rd; rs1_id = rs1; rs2_id = rs2; imm_id = imm;
        alusrc_id = as; regwrite_id = rw; memread_id = mr; memtoreg_id = mr;
        memwrite_id = mw; branch_id = br; alu_op_id = op;
        pc_id = pc_id + 4; rs1_data_id = $urandom; rs2_data_id = $urandom;
        funct3_id = rd[2:0] ^ rs1[2:0]; funct7_id = {rs2, op};
    endtask

    initial begin
        #3;
        chk("rst_valid", {31'd0, valid_ex}, 32'd0);
        chk("rst_count", {16'd0, hazard_count}, 32'd0);
        chk("rst_stall", {31'd0, stall_id}, 32'd0);
        #4 rst = 0;
        tick();
        // addi x5,x1,3
        set_id(1, 5, 1, 0, 3, 1, 1, 0, 0, 0, 2'b10);
        tick();
        chk("addi_rd", {27'd0, rd_ex}, 32'd5);
        chk("addi_imm", imm_ex, 32'd3);
        chk("addi_rw", {31'd0, regwrite_ex}, 32'd1);
        chk("addi_valid", {31'd0, valid_ex}, 32'd1);
        // lw x6 followed by add x7,x6,x2
        set_id(1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
        tick();
        set_id(1, 7, 6, 2, 0, 0, 1, 0, 0, 0, 2'b10);
        #1 chk("lu_stall", {31'd0, stall_id}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, valid_ex}, 32'd0);
        chk("lu_bubble_rw", {31'd0, regwrite_ex}, 32'd0);
        chk("lu_count", {16'd0, hazard_count}, 32'd1);
        chk("lu_stall_fall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lu_add_rd", {27'd0, rd_ex}, 32'd7);
        chk("lu_add_valid", {31'd0, valid_ex}, 32'd1);
        // rs2 filter: immediate form ignores rs2, store does not
        set_id(1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
        tick();
        set_id(1, 7, 2, 6, 5, 1, 1, 0, 0, 0, 2'b10);
        #1 chk("rs2_addi_stall", {31'd0, stall_id}, 32'd0);
        set_id(1, 0, 2, 6, 8, 1, 0, 0, 1, 0, 2'b00);
        #1 chk("rs2_sw_stall", {31'd0, stall_id}, 32'd1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        // load to x0 never stalls
        set_id(1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
        tick();
        set_id(1, 8, 0, 0, 1, 1, 1, 0, 0, 0, 2'b10);
        #1 chk("x0_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("x0_valid", {31'd0, valid_ex}, 32'd1);
        chk("x0_count", {16'd0, hazard_count}, 32'd1);
        // hold beats flush for three edges, then flush takes effect
        set_id(1, 9, 1, 0, 4, 1, 1, 0, 0, 0, 2'b10);
        tick();
        set_id(1, 10, 1, 0, 4, 1, 1, 0, 0, 0, 2'b10);
        hold = 1; flush_ex = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd", {27'd0, rd_ex}, 32'd9);
            chk("hold_valid", {31'd0, valid_ex}, 32'd1);
        end
        hold = 0;
        tick();
        chk("flush_valid", {31'd0, valid_ex}, 32'd0);
        chk("flush_rw", {31'd0, regwrite_ex}, 32'd0);
        flush_ex = 0;
        // flush overrides a load-use hazard
        set_id(1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
        tick();
        set_id(1, 7, 6, 2, 0, 0, 1, 0, 0, 0, 2'b10);
        flush_ex = 1;
        #1 chk("flush_stall", {31'd0, stall_id}, 32'd0);
        tick();
        chk("flush_count", {16'd0, hazard_count}, 32'd1);
        flush_ex = 0;
        // asynchronous reset between edges
        set_id(1, 5, 1, 0, 3, 1, 1, 0, 0, 0, 2'b10);
        tick();
        chk("pre_rst_rw", {31'd0, regwrite_ex}, 32'd1);
        rst = 1;
        #1 chk("arst_rw", {31'd0, regwrite_ex}, 32'd0);
        chk("arst_count", {16'd0, hazard_count}, 32'd0);
        #1 rst = 0;
        // reset in the middle of a stall
        set_id(1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
        tick();
        set_id(1, 7, 6, 2, 0, 0, 1, 0, 0, 0, 2'b10);
        rst = 1;
        #1 rst = 0;
        tick();
        tick();
        // saturation from a preloaded count
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        preload = 1;
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        preload = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            set_id(1, 6, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);
            tick();
            set_id(1, 7, 6, 2, 0, 0, 1, 0, 0, 0, 2'b10);
            tick();
            tick();
        end
        chk("sat_count", {16'd0, hazard_count}, 32'h0000FFFF);
        // mixed traffic with occasional hold and flush
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 2'($urandom));
            hold = ($urandom_range(0, 5) == 0);
            flush_ex = ($urandom_range(0, 5) == 0);
            tick();
        end
        hold = 0; flush_ex = 0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
